// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the multi-word add sequencer.
// Provides the FSM state encoding and a word-select helper for wide vectors.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    localparam int WORD_W          = 16;
    localparam int ADD_LAT_DEFAULT = 2;
    localparam int MAX_WORDS       = 16;
    localparam int PAD_W           = WORD_W * MAX_WORDS;

    // Word i occupies bits [WORD_W*i +: WORD_W]; callers zero-extend to PAD_W.
    function automatic logic [WORD_W-1:0] word_sel(input logic [PAD_W-1:0] v, input int i);
        return v[i*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Bundle of the operand/result handshakes and the adder-side port of the sequencer.
// The slave modport is the sequencer; the master modport is its parent (requester + adder).
interface wide_add_sequencer_if
    import wide_add_pkg::*;
#(
    parameter int W     = WORD_W,
    parameter int WORDS = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [W*WORDS-1:0] a;
    logic [W*WORDS-1:0] b;
    logic               cin;
    logic               out_valid;
    logic               out_ready;
    logic [W*WORDS-1:0] sum;
    logic               cout;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic               add_cin;
    logic [W-1:0]       add_sum;
    logic               add_cout;
    logic               busy;

    modport master (
        output in_valid, a, b, cin, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, sum, cout, add_a, add_b, add_cin, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready, add_sum, add_cout,
        output in_ready, out_valid, sum, cout, add_a, add_b, add_cin, busy
    );

endinterface

// File: rtl/wide_add_sequencer.sv
// Feeds a registered W-bit adder one word at a time, LSW first, chaining carries,
// and reassembles the WORDS*W-bit sum behind a valid/ready result handshake.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int W       = WORD_W,
    parameter int WORDS   = 4,
    parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    wide_add_sequencer_if.slave bus
);

    localparam int N     = W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = $clog2(ADD_LAT + 1);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [N-1:0]       a_q,         a_d;
    logic [N-1:0]       b_q,         b_d;
    logic [N-1:0]       sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       add_a_q,     add_a_d;
    logic [W-1:0]       add_b_q,     add_b_d;
    logic               add_cin_q,   add_cin_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    idx_d     = '0;
                    add_a_d   = word_sel(PAD_W'(bus.a), 0);
                    add_b_d   = word_sel(PAD_W'(bus.b), 0);
                    add_cin_d = bus.cin;
                    cnt_d     = CNT_W'(ADD_LAT);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // The counter reaching zero means the adder output now reflects the held inputs.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sum_d[idx_q*W +: W] = bus.add_sum;
                    if (idx_q != IDX_W'(WORDS - 1)) begin
                        idx_d     = idx_q + 1'b1;
                        add_a_d   = word_sel(PAD_W'(a_q), int'(idx_q) + 1);
                        add_b_d   = word_sel(PAD_W'(b_q), int'(idx_q) + 1);
                        add_cin_d = bus.add_cout;
                        cnt_d     = CNT_W'(ADD_LAT);
                    end else begin
                        cout_d      = bus.add_cout;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-word add sequencer that sits directly upstream of the registered 16-bit ripple-carry adder and consumes its outputs.
- Accepts WORDS*W-bit operands over a valid/ready handshake.
- Issues them to the adder one W-bit word at a time, LSW first, chaining each word's carry-out into the next word's carry-in.
- Reassembles the wide sum and returns it over a valid/ready result handshake.
- The adder is instantiated by the parent; this block only drives its A_in/B_in/Cin_in and samples its SUM_out/Cout_out.

Parameters:
W, 16, adder word width; must equal the adder width.
WORDS, 4, number of words per operand; must be >= 2.
ADD_LAT, 2, adder latency in clock edges (input register plus output register); must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operand request valid.
in_ready  out  1  sequencer can accept an operand.
a  in  W*WORDS  operand A.
b  in  W*WORDS  operand B.
cin  in  1  carry into word 0.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
sum  out  W*WORDS  wide sum.
cout  out  1  carry out of the last word.
add_a  out  W  to adder A_in.
add_b  out  W  to adder B_in.
add_cin  out  1  to adder Cin_in.
add_sum  in  W  from adder SUM_out.
add_cout  in  1  from adder Cout_out.
busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). All state is in registers, and reset acts immediately.
- Reset values:
  - state = IDLE; word index = 0; wait counter = 0.
  - sum = 0, cout = 0, out_valid = 0.
  - add_a = 0, add_b = 0, add_cin = 0.
  - Latched operands = 0.
  - in_ready = 1 once reset deasserts; busy = 0.
- Word i of any wide vector is bits [W*i+W-1 : W*i].
- States: IDLE, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1: latch a, b and cin; set idx = 0.
  - On that same edge, load add_a = a word 0, add_b = b word 0, add_cin = cin.
  - Load the wait counter with ADD_LAT and go to WAIT.
- WAIT:
  - add_a, add_b and add_cin are held stable.
  - While counter != 0, decrement each edge.
  - On the edge where counter == 0: write add_sum into sum word idx and capture add_cout into a carry register.
  - If idx < WORDS-1 on that edge:
    - idx = idx+1.
    - Load add_a/add_b with the next word and add_cin = add_cout.
    - Reload the counter with ADD_LAT and stay in WAIT.
  - If idx == WORDS-1 on that edge: set cout = add_cout and out_valid = 1, and go to DONE.
- Timing: each word costs ADD_LAT+1 cycles. Default latency from the accept edge to out_valid = WORDS*(ADD_LAT+1) = 12 cycles.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - On an edge with out_ready=1: clear out_valid and go to IDLE.
  - in_ready stays 0 until the cycle after that handshake; there is no same-cycle bypass into a new operation.
- in_ready = 0 in WAIT and DONE. in_valid and operand changes there are ignored.
- sum words not yet written in the current operation retain their previous values. They are observable only while out_valid=0.
- Arithmetic: modulo 2^(W*WORDS); the final carry is reported only on cout.
- Reset mid-operation: the operation is aborted and discarded, no out_valid pulse is produced, and outputs return to reset values. Adder results arriving after reset release are never sampled, because the block is in IDLE.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package `wide_add_pkg`:
  - State enum {IDLE, WAIT, DONE}.
  - Constants WORD_W=16 and ADD_LAT_DEFAULT=2.
  - A word-select helper function.
- No sub-module. The word mux and the sum-word write are small enough to stay inline.
- The bench pairs this block with the existing 16-bit registered adder.

Test Plan:
1. a=0x0000_0000_0000_0001, b=0xFFFF_FFFF_FFFF_FFFF, cin=0 -> sum=0x0000_0000_0000_0000, cout=1; out_valid rises exactly 12 cycles after the accept edge.
2. a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321, cin=1 -> sum=0x2222_2222_2222_2212, cout=0; add_cin sequence observed on the adder port = 1,1,1,1.
3. a=0x0000_FFFF_FFFF_FFFF, b=0x0000_0000_0000_0001, cin=0 -> sum=0x0001_0000_0000_0000, cout=0; add_cin sequence = 0,1,1,1.
4. Backpressure:
   - Stimulus: out_ready held low for 5 cycles after out_valid rises, with in_valid=1 carrying a second operand throughout.
   - Required: sum/cout stable, in_ready=0, second operand not accepted; it is accepted in the first IDLE cycle after the out handshake, with the correct second result 12 cycles later.
5. Reset mid-operation:
   - Stimulus: assert reset in cycle 6 of an operation.
   - Required: out_valid=0, sum=0, busy=0 immediately; in_ready=1 after release; no result is ever produced for the aborted operation; a subsequent a=5, b=7, cin=0 yields sum=12, cout=0.
6. Back-to-back throughput:
   - Stimulus: 3 operations with in_valid and out_ready tied high.
   - Required: accepts spaced exactly 14 cycles apart (12 + 1 DONE + 1 IDLE); all three sums correct.
